drum_hit_detector: RTL and testbench

Parametrised multi-pad hit detector for the electric drum set. It drives the modular ADC command channel round-robin over `NUM_CH` Arduino analog inputs and tracks each pad's samples through a per-channel attack/peak/holdoff state machine. For each strike it emits exactly one hit event, carrying the channel and its peak velocity, on a valid/ready stream. It sits between the `adc_qsys` command/response ports and the sound/LED logic, replacing the fixed five-pad threshold compare.

---
 rtl/drum_hit_detector.sv | 270 +++++++++++++++++++++++++++
 tb/tb_drum_hit_detector.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_hit_detector.sv
// drum_hit_detector: round-robin ADC sequencer with per-pad attack/peak/holdoff
// strike detection and a single-register valid/ready hit event output.
// Optional feature macro: DRUM_HIT_COUNT_EN adds per-pad accepted-hit counters.
module drum_hit_detector #(
    parameter int NUM_CH       = 5,
    parameter int DATA_W       = 12,
    parameter int CH_BASE      = 1,
    parameter int MIN_HIT      = 100,
    parameter int MIN_FOOT     = 1024,
    parameter int FOOT_CH      = 4,
    parameter int PEAK_WIN     = 4,
    parameter int HOLD_SAMPLES = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    output logic [4:0]        cmd_channel,
    input  logic              rsp_valid,
    input  logic [4:0]        rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [3:0]        hit_channel,
    output logic [DATA_W-1:0] hit_velocity,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] overrun
`ifdef DRUM_HIT_COUNT_EN
    ,
    input  logic [3:0]        count_sel,
    output logic [7:0]        hit_count
`endif
);

    localparam int WIN_W  = $clog2(PEAK_WIN + 1);
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_HOLD
    } pad_st_t;

    function automatic logic [31:0] thr_of(input int idx);
        return (idx == FOOT_CH) ? 32'(MIN_FOOT) : 32'(MIN_HIT);
    endfunction

    logic [3:0]        seq_q;
    logic [5:0]        ch_off;
    logic              ch_ge_base;

    pad_st_t           st_q   [NUM_CH];
    pad_st_t           st_d   [NUM_CH];
    logic [DATA_W-1:0] peak_q [NUM_CH];
    logic [DATA_W-1:0] peak_d [NUM_CH];
    logic [DATA_W-1:0] peak_mx[NUM_CH];
    logic [WIN_W-1:0]  win_q  [NUM_CH];
    logic [WIN_W-1:0]  win_d  [NUM_CH];
    logic [HOLD_W-1:0] hold_q [NUM_CH];
    logic [HOLD_W-1:0] hold_d [NUM_CH];
    logic [DATA_W-1:0] rvel   [NUM_CH];
    logic [DATA_W-1:0] pvel_q [NUM_CH];

    logic [NUM_CH-1:0] smp;
    logic [NUM_CH-1:0] above;
    logic [NUM_CH-1:0] win_last;
    logic [NUM_CH-1:0] hold_done;
    logic [NUM_CH-1:0] raise;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] unload;

    logic              out_load;
    logic              any_pend;
    logic [3:0]        sel;
    logic [DATA_W-1:0] sel_vel;

    assign cmd_channel = 5'(CH_BASE) + {1'b0, seq_q};

    // Round-robin command sequencer, advances on every ADC response
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            seq_q <= '0;
        end else if (rsp_valid) begin
            if (seq_q == 4'(NUM_CH - 1))
                seq_q <= '0;
            else
                seq_q <= seq_q + 4'd1;
        end
    end

    // Decode response to a pad strobe and precompute per-pad compares
    always_comb begin
        ch_off     = {1'b0, rsp_channel} - 6'(CH_BASE);
        ch_ge_base = ({1'b0, rsp_channel} >= 6'(CH_BASE));
        for (int i = 0; i < NUM_CH; i++) begin
            smp[i]       = rsp_valid && ch_ge_base && (ch_off == 6'(i));
            above[i]     = 32'(rsp_data) > thr_of(i);
            peak_mx[i]   = (rsp_data > peak_q[i]) ? rsp_data : peak_q[i];
            win_last[i]  = (win_q[i] == WIN_W'(PEAK_WIN - 1));
            hold_done[i] = (hold_q[i] >= HOLD_W'(HOLD_SAMPLES - 1));
        end
    end

    // Pad FSM next-state: only a pad's own sample moves its state
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i] = st_q[i];
            if (smp[i]) begin
                unique case (st_q[i])
                    ST_IDLE: begin
                        if (above[i])
                            st_d[i] = (PEAK_WIN == 1) ? ST_HOLD : ST_ATTACK;
                    end
                    ST_ATTACK: begin
                        if (win_last[i])
                            st_d[i] = ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_done[i] && !above[i])
                            st_d[i] = ST_IDLE;
                    end
                    default: st_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Pad FSM outputs: peak/window/holdoff datapath and event raise
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            peak_d[i] = peak_q[i];
            win_d[i]  = win_q[i];
            hold_d[i] = hold_q[i];
            raise[i]  = 1'b0;
            rvel[i]   = peak_q[i];
            if (smp[i]) begin
                unique case (st_q[i])
                    ST_IDLE: begin
                        if (above[i]) begin
                            peak_d[i] = rsp_data;
                            win_d[i]  = WIN_W'(1);
                            hold_d[i] = '0;
                            if (PEAK_WIN == 1) begin
                                raise[i] = 1'b1;
                                rvel[i]  = rsp_data;
                            end
                        end
                    end
                    ST_ATTACK: begin
                        peak_d[i] = peak_mx[i];
                        win_d[i]  = win_q[i] + WIN_W'(1);
                        if (win_last[i]) begin
                            raise[i]  = 1'b1;
                            rvel[i]   = peak_mx[i];
                            hold_d[i] = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!hold_done[i])
                            hold_d[i] = hold_q[i] + HOLD_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pad FSM state, datapath and level registers
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            level <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= ST_IDLE;
                peak_q[i] <= '0;
                win_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= st_d[i];
                peak_q[i] <= peak_d[i];
                win_q[i]  <= win_d[i];
                hold_q[i] <= hold_d[i];
                if (smp[i])
                    level[i] <= above[i];
            end
        end
    end

    // Lowest-index pending pad wins the output register
    always_comb begin
        sel      = '0;
        sel_vel  = '0;
        any_pend = |pend_q;
        out_load = !hit_valid || hit_ready;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel     = 4'(i);
                sel_vel = pvel_q[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++)
            unload[i] = out_load && any_pend && (sel == 4'(i));
    end

    // Per-pad pending slot; a new raise beats a same-cycle unload
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pend_q  <= '0;
            overrun <= '0;
            for (int i = 0; i < NUM_CH; i++)
                pvel_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (raise[i]) begin
                    pend_q[i] <= 1'b1;
                    pvel_q[i] <= rvel[i];
                    if (pend_q[i] && !unload[i])
                        overrun[i] <= 1'b1;
                end else if (unload[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Output register, held stable while stalled
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            hit_valid    <= 1'b0;
            hit_channel  <= '0;
            hit_velocity <= '0;
        end else if (out_load) begin
            if (any_pend) begin
                hit_valid    <= 1'b1;
                hit_channel  <= sel;
                hit_velocity <= sel_vel;
            end else begin
                hit_valid    <= 1'b0;
            end
        end
    end

`ifdef DRUM_HIT_COUNT_EN
    logic [7:0] cnt_q[NUM_CH];
    logic [7:0] cnt_sel;

    // Select the counter to display; out-of-range select reads zero
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (count_sel == 4'(i))
                cnt_sel = cnt_q[i];
    end

    // Saturating per-pad accepted-hit counters and registered readout
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            hit_count <= '0;
            for (int i = 0; i < NUM_CH; i++)
                cnt_q[i] <= '0;
        end else begin
            hit_count <= cnt_sel;
            for (int i = 0; i < NUM_CH; i++)
                if (hit_valid && hit_ready && hit_channel == 4'(i) &&
                    cnt_q[i] != 8'hFF)
                    cnt_q[i] <= cnt_q[i] + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_drum_hit_detector.sv
// tb_drum_hit_detector: directed and randomized checks of drum_hit_detector
// against a sample-level behavioural model of the pads and the event stream.
module tb_drum_hit_detector;

    localparam int NUM_CH       = 5;
    localparam int DATA_W       = 12;
    localparam int CH_BASE      = 1;
    localparam int MIN_HIT      = 100;
    localparam int MIN_FOOT     = 1024;
    localparam int FOOT_CH      = 4;
    localparam int PEAK_WIN     = 4;
    localparam int HOLD_SAMPLES = 16;

    logic              sys_clk;
    logic              reset;
    logic [4:0]        cmd_channel;
    logic              rsp_valid;
    logic [4:0]        rsp_channel;
    logic [DATA_W-1:0] rsp_data;
    logic              hit_valid;
    logic              hit_ready;
    logic [3:0]        hit_channel;
    logic [DATA_W-1:0] hit_velocity;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] overrun;
`ifdef DRUM_HIT_COUNT_EN
    logic [3:0]        count_sel;
    logic [7:0]        hit_count;
`endif

    drum_hit_detector #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_BASE(CH_BASE),
        .MIN_HIT(MIN_HIT), .MIN_FOOT(MIN_FOOT), .FOOT_CH(FOOT_CH),
        .PEAK_WIN(PEAK_WIN), .HOLD_SAMPLES(HOLD_SAMPLES)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .cmd_channel(cmd_channel),
        .rsp_valid(rsp_valid),
        .rsp_channel(rsp_channel),
        .rsp_data(rsp_data),
        .hit_valid(hit_valid),
        .hit_ready(hit_ready),
        .hit_channel(hit_channel),
        .hit_velocity(hit_velocity),
        .level(level),
        .overrun(overrun)
`ifdef DRUM_HIT_COUNT_EN
        ,
        .count_sel(count_sel),
        .hit_count(hit_count)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int ch;
        int vel;
    } ev_t;

    int n_checks;
    int n_errors;
    ev_t dut_log[$];

    // behavioural model state
    int                m_seq;
    bit                m_armed [NUM_CH];
    bit                m_hold  [NUM_CH];
    int                m_since [NUM_CH];
    int                m_win   [NUM_CH][$];
    logic [NUM_CH-1:0] m_level;
    logic [NUM_CH-1:0] m_ov;
    bit                m_pend  [NUM_CH];
    int                m_pvel  [NUM_CH];
    bit                m_out_v;
    int                m_out_ch;
    int                m_out_vel;
    int                m_cnt   [NUM_CH];
    int                m_hc;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp_v, $time);
        end
    endtask

    function automatic int thr_of(input int c);
        return (c == FOOT_CH) ? MIN_FOOT : MIN_HIT;
    endfunction

    task automatic model_reset();
        m_seq     = 0;
        m_level   = '0;
        m_ov      = '0;
        m_out_v   = 1'b0;
        m_out_ch  = 0;
        m_out_vel = 0;
        m_hc      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_armed[i] = 1'b1;
            m_hold[i]  = 1'b0;
            m_since[i] = 0;
            m_win[i].delete();
            m_pend[i]  = 1'b0;
            m_pvel[i]  = 0;
            m_cnt[i]   = 0;
        end
    endtask

    // A strike: first sample above threshold opens a window of PEAK_WIN
    // own samples whose maximum is the velocity; then at least
    // HOLD_SAMPLES samples must pass, and a quiet sample re-arms the pad.
    task automatic pad_sample(input int c, input int s,
                              output bit raise, output int vel);
        int thr;
        int mx;
        thr   = thr_of(c);
        raise = 1'b0;
        vel   = 0;
        m_level[c] = (s > thr);
        if (m_armed[c] && s > thr)
            m_armed[c] = 1'b0;
        if (!m_armed[c] && !m_hold[c]) begin
            m_win[c].push_back(s);
            if (m_win[c].size() == PEAK_WIN) begin
                mx = m_win[c][0];
                for (int k = 1; k < m_win[c].size(); k++)
                    if (m_win[c][k] > mx)
                        mx = m_win[c][k];
                raise      = 1'b1;
                vel        = mx;
                m_win[c].delete();
                m_hold[c]  = 1'b1;
                m_since[c] = 0;
            end
        end else if (m_hold[c]) begin
            m_since[c]++;
            if (m_since[c] >= HOLD_SAMPLES && s <= thr) begin
                m_hold[c]  = 1'b0;
                m_armed[c] = 1'b1;
            end
        end
    endtask

    // Advance the model across one clock edge with the given inputs
    task automatic model_edge(input bit v, input int ch, input int d,
                              input bit rdy);
        bit raise;
        int rvel;
        int rc;
        int lo;
        raise = 1'b0;
        rvel  = 0;
        rc    = 0;
        lo    = -1;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m_pend[i])
                lo = i;
        if (v) begin
            m_seq = (m_seq + 1) % NUM_CH;
            if (ch >= CH_BASE && ch - CH_BASE < NUM_CH) begin
                rc = ch - CH_BASE;
                pad_sample(rc, d, raise, rvel);
            end
        end
`ifdef DRUM_HIT_COUNT_EN
        m_hc = (int'(count_sel) < NUM_CH) ? m_cnt[count_sel] : 0;
        if (m_out_v && rdy && m_cnt[m_out_ch] < 255)
            m_cnt[m_out_ch]++;
`endif
        if (!m_out_v || rdy) begin
            if (lo >= 0) begin
                m_out_v    = 1'b1;
                m_out_ch   = lo;
                m_out_vel  = m_pvel[lo];
                m_pend[lo] = 1'b0;
            end else begin
                m_out_v = 1'b0;
            end
        end
        if (raise) begin
            if (m_pend[rc])
                m_ov[rc] = 1'b1;
            m_pend[rc] = 1'b1;
            m_pvel[rc] = rvel;
        end
    endtask

    task automatic post_check();
        check_eq("cmd_channel", 32'(cmd_channel), CH_BASE + m_seq);
        check_eq("hit_valid", 32'(hit_valid), 32'(m_out_v));
        if (m_out_v) begin
            check_eq("hit_channel", 32'(hit_channel), m_out_ch);
            check_eq("hit_velocity", 32'(hit_velocity), m_out_vel);
        end
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("overrun", 32'(overrun), 32'(m_ov));
`ifdef DRUM_HIT_COUNT_EN
        check_eq("hit_count", 32'(hit_count), m_hc);
`endif
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit rdy);
        ev_t e;
        rsp_valid   = v;
        rsp_channel = 5'(ch);
        rsp_data    = d[DATA_W-1:0];
        hit_ready   = rdy;
        if (hit_valid && rdy) begin
            e.ch  = int'(hit_channel);
            e.vel = int'(hit_velocity);
            dut_log.push_back(e);
        end
        model_edge(v, ch, d, rdy);
        @(posedge sys_clk);
        #1;
        post_check();
    endtask

    task automatic do_reset(input int n);
        rsp_valid = 1'b0;
        hit_ready = 1'b0;
        reset     = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
            check_eq("rst_cmd", 32'(cmd_channel), CH_BASE);
            check_eq("rst_valid", 32'(hit_valid), 0);
            check_eq("rst_chan", 32'(hit_channel), 0);
            check_eq("rst_vel", 32'(hit_velocity), 0);
            check_eq("rst_level", 32'(level), 0);
            check_eq("rst_ovr", 32'(overrun), 0);
`ifdef DRUM_HIT_COUNT_EN
            check_eq("rst_count", 32'(hit_count), 0);
`endif
        end
        reset = 1'b0;
        model_reset();
        dut_log.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        rsp_valid   = 1'b0;
        rsp_channel = '0;
        rsp_data    = '0;
        hit_ready   = 1'b0;
`ifdef DRUM_HIT_COUNT_EN
        count_sel   = '0;
`endif
        model_reset();
        do_reset(2);

        // sequencer walk
        for (int k = 0; k < 12; k++) begin
            step(1'b1, CH_BASE + (k % NUM_CH), 0, 1'b1);
            check_eq("seq_walk", 32'(cmd_channel),
                     CH_BASE + ((k + 1) % NUM_CH));
        end

        // single strike on pad 0
        dut_log.delete();
        step(1'b1, 1, 50, 1'b1);
        step(1'b1, 1, 300, 1'b1);
        step(1'b1, 1, 800, 1'b1);
        step(1'b1, 1, 600, 1'b1);
        step(1'b1, 1, 200, 1'b1);
        check_eq("strike_lat1", 32'(hit_valid), 0);
        step(1'b0, 0, 0, 1'b1);
        check_eq("strike_lat2", 32'(hit_valid), 1);
        check_eq("strike_vel0", 32'(hit_velocity), 800);
        repeat (3) step(1'b1, 1, 200, 1'b1);
        repeat (3) step(1'b0, 0, 0, 1'b1);
        check_eq("strike_cnt", dut_log.size(), 1);
        if (dut_log.size() > 0) begin
            check_eq("strike_ch", dut_log[0].ch, 0);
            check_eq("strike_vel", dut_log[0].vel, 800);
        end

        // foot pad threshold boundary
        dut_log.delete();
        step(1'b1, 5, 1000, 1'b1);
        check_eq("foot_1000", 32'(level[FOOT_CH]), 0);
        step(1'b1, 5, 1024, 1'b1);
        check_eq("foot_1024", 32'(level[FOOT_CH]), 0);
        step(1'b1, 5, 1025, 1'b1);
        check_eq("foot_1025", 32'(level[FOOT_CH]), 1);
        step(1'b1, 5, 1100, 1'b1);
        step(1'b1, 5, 1050, 1'b1);
        step(1'b1, 5, 0, 1'b1);
        repeat (3) step(1'b0, 0, 0, 1'b1);
        check_eq("foot_cnt", dut_log.size(), 1);
        if (dut_log.size() > 0) begin
            check_eq("foot_ch", dut_log[0].ch, 4);
            check_eq("foot_vel", dut_log[0].vel, 1100);
        end

        // holdoff and re-arm on pad 1
        dut_log.delete();
        repeat (4) step(1'b1, 2, 400, 1'b1);
        repeat (15) step(1'b1, 2, 500, 1'b1);
        check_eq("hold_noretrig", dut_log.size(), 1);
        step(1'b1, 2, 50, 1'b1);
        step(1'b1, 2, 900, 1'b1);
        repeat (3) step(1'b1, 2, 0, 1'b1);
        repeat (3) step(1'b0, 0, 0, 1'b1);
        check_eq("rearm_cnt", dut_log.size(), 2);
        if (dut_log.size() > 1) begin
            check_eq("rearm_ch", dut_log[1].ch, 1);
            check_eq("rearm_vel", dut_log[1].vel, 900);
        end
        repeat (15) step(1'b1, 2, 0, 1'b1);
        step(1'b1, 2, 900, 1'b1);
        step(1'b1, 2, 50, 1'b1);
        repeat (4) step(1'b0, 0, 0, 1'b1);
        check_eq("hold_edge", dut_log.size(), 2);

        // backpressure, priority and overrun on pads 2 and 3
        dut_log.delete();
        step(1'b1, 3, 500, 1'b0);
        step(1'b1, 4, 600, 1'b0);
        step(1'b1, 3, 700, 1'b0);
        step(1'b1, 4, 650, 1'b0);
        step(1'b1, 3, 300, 1'b0);
        step(1'b1, 4, 400, 1'b0);
        step(1'b1, 3, 200, 1'b0);
        step(1'b1, 4, 100, 1'b0);
        check_eq("bp_valid", 32'(hit_valid), 1);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 4, 10, 1'b0);
            check_eq("bp_hold_ch", 32'(hit_channel), 2);
            check_eq("bp_hold_vel", 32'(hit_velocity), 700);
        end
        check_eq("bp_no_ovr", 32'(overrun), 0);
        step(1'b1, 4, 1000, 1'b0);
        step(1'b1, 4, 1200, 1'b0);
        step(1'b1, 4, 300, 1'b0);
        step(1'b1, 4, 0, 1'b0);
        check_eq("bp_ovr", 32'(overrun), 32'h8);
        repeat (4) step(1'b0, 0, 0, 1'b1);
        check_eq("bp_cnt", dut_log.size(), 2);
        if (dut_log.size() > 1) begin
            check_eq("bp_first_ch", dut_log[0].ch, 2);
            check_eq("bp_first_vel", dut_log[0].vel, 700);
            check_eq("bp_second_ch", dut_log[1].ch, 3);
            check_eq("bp_second_vel", dut_log[1].vel, 1200);
        end

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit v;
            bit r;
            int ch;
            int d;
            v  = ($urandom_range(0, 99) < 80);
            ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                             : CH_BASE + m_seq;
            d  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 150))
                                             : int'($urandom_range(0, 4095));
            r  = ($urandom_range(0, 3) != 0);
            step(v, ch, d, r);
        end

        // reset mid-strike drops everything in flight
        step(1'b1, CH_BASE + m_seq, 3000, 1'b0);
        step(1'b1, CH_BASE + m_seq, 3000, 1'b0);
        do_reset(1);
        repeat (4) step(1'b1, 1, 500, 1'b1);
        repeat (3) step(1'b0, 0, 0, 1'b1);
        check_eq("post_rst_cnt", dut_log.size(), 1);
        if (dut_log.size() > 0)
            check_eq("post_rst_vel", dut_log[0].vel, 500);

`ifdef DRUM_HIT_COUNT_EN
        // saturating hit counter on pad 0
        repeat (16) step(1'b1, 1, 0, 1'b1);
        count_sel = 4'd0;
        for (int n = 0; n < 300; n++) begin
            repeat (4) step(1'b1, 1, 900, 1'b1);
            repeat (16) step(1'b1, 1, 0, 1'b1);
        end
        repeat (3) step(1'b0, 0, 0, 1'b1);
        check_eq("count_sat", 32'(hit_count), 255);
        count_sel = 4'd7;
        step(1'b0, 0, 0, 1'b1);
        check_eq("count_oor", 32'(hit_count), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
